// File: rtl/apb3_cmd_master.sv
// Command-to-APB3 bridge. Accepts one command at a time on a valid/ready handshake,
// runs the APB3 SETUP/ACCESS sequence, and returns the result on a valid/ready response port.
// Every output comes straight from a flop.
//
// Ports:
//   i_apb_pclk, i_apb_presetn    clock, asynchronous active-low reset
//   i_cmd_*, o_cmd_ready         command channel (addr, wdata, write)
//   o_rsp_*, i_rsp_ready         response channel (rdata, slverr, timeout)
//   o_apb_*, i_apb_*             APB3 requester signals
module apb3_cmd_master #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      i_apb_pclk,
  input  logic                      i_apb_presetn,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
  input  logic                      i_cmd_write,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                      o_rsp_slverr,
  output logic                      o_rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
  output logic                      o_apb_pwrite,
  output logic                      o_apb_psel,
  output logic                      o_apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
  input  logic                      i_apb_pready,
  input  logic                      i_apb_pslverr
);

  // A zero limit disables the counter; keep at least one bit so the width stays legal.
  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e state_q, state_d;

  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_slverr_q, rsp_slverr_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic accept;
  logic access_wait;
  logic timed_out;

  // Handshake uses the registered ready, so nothing is taken in the first cycle after reset.
  assign accept      = cmd_ready_q & i_cmd_valid;
  assign access_wait = (state_q == StAccess) & ~i_apb_pready;
  assign timed_out   = TimeoutEn & access_wait & (cnt_q == CntLast);

  // State register
  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (i_apb_pready || timed_out) state_d = StResp;
      StResp:   if (i_rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    cmd_ready_d   = (state_d == StIdle);
    rsp_valid_d   = (state_d == StResp);
    psel_d        = (state_d == StSetup) || (state_d == StAccess);
    penable_d     = (state_d == StAccess);
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    if (accept) begin
      paddr_d  = i_cmd_addr;
      pwdata_d = i_cmd_wdata;
      pwrite_d = i_cmd_write;
      cnt_d    = '0;
    end else if (TimeoutEn && access_wait) begin
      cnt_d = cnt_q + CntW'(1);
    end

    // pready wins over a timeout that would fire in the same cycle.
    if (state_q == StAccess) begin
      if (i_apb_pready) begin
        rsp_rdata_d   = pwrite_q ? '0 : i_apb_prdata;
        rsp_slverr_d  = i_apb_pslverr;
        rsp_timeout_d = 1'b0;
      end else if (timed_out) begin
        rsp_rdata_d   = '0;
        rsp_slverr_d  = 1'b1;
        rsp_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) begin
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      cnt_q         <= cnt_d;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_slverr  = rsp_slverr_q;
  assign o_rsp_timeout = rsp_timeout_q;
  assign o_apb_paddr   = paddr_q;
  assign o_apb_pwdata  = pwdata_q;
  assign o_apb_pwrite  = pwrite_q;
  assign o_apb_psel    = psel_q;
  assign o_apb_penable = penable_q;

endmodule

// File: tb/tb_apb3_cmd_master.sv
// Self-checking bench for apb3_cmd_master (TIMEOUT_CYCLES = 8). The bench drives inputs
// on the falling edge and samples outputs there, away from the active rising edge.
module tb_apb3_cmd_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata = '0;
  logic        pwrite, psel, penable, pready = 1'b0, pslverr = 1'b0;

  apb3_cmd_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_apb_pclk    (clk),
    .i_apb_presetn (rstn),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_wdata   (cmd_wdata),
    .i_cmd_write   (cmd_write),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_slverr  (rsp_slverr),
    .o_rsp_timeout (rsp_timeout),
    .o_apb_paddr   (paddr),
    .o_apb_pwdata  (pwdata),
    .o_apb_pwrite  (pwrite),
    .o_apb_psel    (psel),
    .o_apb_penable (penable),
    .i_apb_prdata  (prdata),
    .i_apb_pready  (pready),
    .i_apb_pslverr (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;     // pready rises in ACCESS cycle waits+1
    logic        stuck;     // pready never rises
    logic [31:0] prdata;
    logic        slverr;
    int          hold;      // cycles rsp_ready stays low in RESP
    logic [31:0] exp_rdata;
    logic        exp_slverr;
    logic        exp_timeout;
    int          exp_acc;   // expected ACCESS cycles
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad = 0;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    rsp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_rdata"}, rsp_rdata, e.rdata);
    check({tag, "_slverr"}, rsp_slverr, e.slverr);
    check({tag, "_timeout"}, rsp_timeout, e.timeout);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int acc;
    bit done;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_write = v.write;
    rsp_ready = 1'b0; pready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check({tag, "_accept"}, 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    sb.push_back('{v.exp_rdata, v.exp_slverr, v.exp_timeout});
    @(negedge clk);  // SETUP
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~v.write;
    check({tag, "_setup"}, {psel, penable}, 2'b10);
    check({tag, "_paddr"}, paddr, v.addr);
    check({tag, "_pwdata"}, pwdata, v.wdata);
    check({tag, "_pwrite"}, pwrite, v.write);
    acc = 0;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!(psel && penable)) begin
        done = 1'b1;
        break;
      end
      acc++;
      if (paddr !== v.addr) check({tag, "_paddr_stable"}, paddr, v.addr);
      if (!v.stuck && acc == v.waits + 1) begin
        pready = 1'b1; prdata = v.prdata; pslverr = v.slverr;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    check({tag, "_access_end"}, done, 1'b1);
    check({tag, "_acc_cycles"}, acc, v.exp_acc);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_resp_apb"}, {psel, penable, cmd_ready}, 3'b000);
    pop_check(tag);
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1; cmd_addr = $urandom;
      @(negedge clk);
      check({tag, "_hold"}, {rsp_valid, cmd_ready, psel, rsp_rdata, paddr},
            {1'b1, 1'b0, 1'b0, v.exp_rdata, v.addr});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_to_idle"}, {rsp_valid, cmd_ready}, 2'b01);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc[$];
    vecs[0] = '{write: 1'b1, addr: 32'h10, wdata: 32'hA5, waits: 0, stuck: 1'b0,
                prdata: 32'hFFFF_FFFF, slverr: 1'b0, hold: 0, exp_rdata: 32'h0,
                exp_slverr: 1'b0, exp_timeout: 1'b0, exp_acc: 1};
    vecs[1] = '{write: 1'b0, addr: 32'h04, wdata: 32'h0, waits: 5, stuck: 1'b0,
                prdata: 32'h1234_5678, slverr: 1'b0, hold: 0, exp_rdata: 32'h1234_5678,
                exp_slverr: 1'b0, exp_timeout: 1'b0, exp_acc: 6};
    vecs[2] = '{write: 1'b0, addr: 32'h08, wdata: 32'h0, waits: 0, stuck: 1'b0,
                prdata: 32'hDEAD_BEEF, slverr: 1'b1, hold: 0, exp_rdata: 32'hDEAD_BEEF,
                exp_slverr: 1'b1, exp_timeout: 1'b0, exp_acc: 1};
    vecs[3] = '{write: 1'b0, addr: 32'h0C, wdata: 32'h0, waits: 0, stuck: 1'b1,
                prdata: 32'h0, slverr: 1'b0, hold: 0, exp_rdata: 32'h0,
                exp_slverr: 1'b1, exp_timeout: 1'b1, exp_acc: 8};
    vecs[4] = '{write: 1'b0, addr: 32'h14, wdata: 32'h0, waits: 7, stuck: 1'b0,
                prdata: 32'h0000_CAFE, slverr: 1'b0, hold: 0, exp_rdata: 32'h0000_CAFE,
                exp_slverr: 1'b0, exp_timeout: 1'b0, exp_acc: 8};
    vecs[5] = '{write: 1'b1, addr: 32'h18, wdata: 32'h5A5A, waits: 2, stuck: 1'b0,
                prdata: 32'h0000_FFFF, slverr: 1'b1, hold: 0, exp_rdata: 32'h0,
                exp_slverr: 1'b1, exp_timeout: 1'b0, exp_acc: 3};
    vecs[6] = '{write: 1'b0, addr: 32'h1C, wdata: 32'h0, waits: 6, stuck: 1'b0,
                prdata: 32'h8765_4321, slverr: 1'b0, hold: 10, exp_rdata: 32'h8765_4321,
                exp_slverr: 1'b0, exp_timeout: 1'b0, exp_acc: 7};

    // Reset state
    #3 rstn = 1'b0;
    #1;
    check("reset_ctrl", {cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, psel, penable, pwrite},
          7'b0);
    check("reset_data", {paddr, pwdata}, 64'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    check("reset_ready_low", cmd_ready, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset pulsed during ACCESS: bus drops at once, no response for the lost command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_write = 1'b0; pready = 1'b0;
    @(negedge clk);  // SETUP
    cmd_valid = 1'b0;
    @(negedge clk);  // ACCESS
    check("mid_access", {psel, penable}, 2'b11);
    #2 rstn = 1'b0;
    #1;
    check("mid_reset_bus", {psel, penable, rsp_valid, cmd_ready}, 4'b0000);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) check("no_rsp_after_reset", rsp_valid, 1'b0);
    end
    check("mid_reset_idle", {cmd_ready, psel}, 2'b10);
    run_vec(vecs[1], 10);

    // Back-to-back: rsp_ready and cmd_valid held, zero-wait slave.
    @(negedge clk);
    rsp_ready = 1'b1; pready = 1'b1; prdata = 32'h600D_F00D; pslverr = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_write = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (rsp_valid) pop_check("b2b");
      if (cmd_ready) begin
        acc_cyc.push_back(c);
        sb.push_back('{32'h600D_F00D, 1'b0, 1'b0});
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) pop_check("b2b_tail");
      @(negedge clk);
    end
    rsp_ready = 1'b0; pready = 1'b0;
    check("b2b_count", acc_cyc.size(), 6);
    for (int k = 1; k < acc_cyc.size(); k++)
      check($sformatf("b2b_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 4);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb3_cmd_master.md
APB3_CMD_MASTER -- requirements
Module: apb3_cmd_master

Interface
REQ-001 Parameters SHALL be: APB_ADDR_WIDTH, default 32, PADDR width; APB_DATA_WIDTH, default 32, PWDATA/PRDATA width; TIMEOUT_CYCLES, default 256, max ACCESS-phase cycles before abort (0 = no timeout).
REQ-002 Ports SHALL be (name  direction  width  meaning):
 i_apb_pclk  in  1  sole clock, rising edge;
 i_apb_presetn  in  1  asynchronous active-low reset;
 i_cmd_valid  in  1  command offered;
 o_cmd_ready  out  1  command accepted when high with i_cmd_valid;
 i_cmd_addr  in  APB_ADDR_WIDTH  target address;
 i_cmd_wdata  in  APB_DATA_WIDTH  write data;
 i_cmd_write  in  1  1 = write, 0 = read;
 o_rsp_valid  out  1  response available;
 i_rsp_ready  in  1  response consumed when high with o_rsp_valid;
 o_rsp_rdata  out  APB_DATA_WIDTH  read data (0 for writes and timeouts);
 o_rsp_slverr  out  1  PSLVERR sampled or timeout;
 o_rsp_timeout  out  1  transfer aborted by timeout;
 o_apb_paddr  out  APB_ADDR_WIDTH  APB3 PADDR;
 o_apb_pwdata  out  APB_DATA_WIDTH  APB3 PWDATA;
 o_apb_pwrite  out  1  APB3 PWRITE;
 o_apb_psel  out  1  APB3 PSEL;
 o_apb_penable  out  1  APB3 PENABLE;
 i_apb_prdata  in  APB_DATA_WIDTH  APB3 PRDATA;
 i_apb_pready  in  1  APB3 PREADY;
 i_apb_pslverr  in  1  APB3 PSLVERR.
REQ-003 Block SHALL use one clock, i_apb_pclk; reset SHALL be i_apb_presetn, asynchronous assert, active-low.

Function
REQ-004 FSM SHALL have states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-005 o_cmd_ready SHALL be 1 only in IDLE; no other state accepts commands.
REQ-006 IDLE, i_cmd_valid=1: latch addr/wdata/write onto o_apb_paddr/pwdata/pwrite; next state SETUP.
REQ-007 SETUP: psel=1, penable=0, exactly one cycle; next state ACCESS.
REQ-008 ACCESS: psel=1, penable=1; held until i_apb_pready=1 or timeout.
REQ-009 ACCESS with i_apb_pready=1: capture i_apb_prdata (reads only, else 0) and i_apb_pslverr; psel=0, penable=0 next cycle; next state RESP.
REQ-010 o_apb_paddr/pwdata/pwrite SHALL remain stable from SETUP through last ACCESS cycle and hold value in IDLE/RESP.
REQ-011 Timeout counter: clog2(TIMEOUT_CYCLES+1) bits, cleared on SETUP entry, +1 per ACCESS cycle with pready=0; at count TIMEOUT_CYCLES-1 with pready=0 abort: psel=penable=0, rsp_slverr=1, rsp_timeout=1, rdata=0, go RESP.
REQ-012 pready=1 in the same cycle the counter reaches its limit SHALL complete normally (no timeout).
REQ-013 TIMEOUT_CYCLES=0: counter inactive, ACCESS waits indefinitely.
REQ-014 RESP: o_rsp_valid=1, rsp fields stable until i_rsp_ready=1; then IDLE next cycle.
REQ-015 Minimum latency: accept edge to o_rsp_valid=1 = 3 cycles (SETUP, ACCESS, RESP), zero-wait slave.
REQ-016 Back-to-back: with i_rsp_ready tied 1 and i_cmd_valid held 1, a new command SHALL be accepted every 4 cycles.
REQ-017 Command inputs SHALL be ignored outside IDLE; i_rsp_ready ignored outside RESP.

Reset
REQ-018 On i_apb_presetn=0, immediately: state IDLE, o_cmd_ready=0 during reset then 1 first cycle after release; o_rsp_valid, o_rsp_slverr, o_rsp_timeout, o_apb_psel, o_apb_penable, o_apb_pwrite=0; o_apb_paddr, o_apb_pwdata, o_rsp_rdata=0; counter=0.
REQ-019 Reset asserted mid-transfer SHALL drop psel/penable asynchronously; no response issued for the aborted command.

Verification
REQ-020 Write addr 0x10, wdata 0xA5, zero-wait slave -> psel one cycle SETUP, one ACCESS, rsp_valid 3 cycles after accept, slverr=0, rdata=0.
REQ-021 Read addr 0x04, slave pready after 5 wait cycles, prdata 0x1234_5678 -> ACCESS lasts 6 cycles, rsp_rdata=0x1234_5678, paddr stable throughout.
REQ-022 Read with pslverr=1 on completion -> rsp_slverr=1, rsp_timeout=0.
REQ-023 TIMEOUT_CYCLES=8, pready stuck 0 -> ACCESS exactly 8 cycles, rsp_slverr=1, rsp_timeout=1, rdata=0; pready on cycle 8 instead -> normal completion.
REQ-024 i_rsp_ready held 0 for 10 cycles -> rsp fields stable, o_cmd_ready=0, psel=0; then 1 -> IDLE next cycle.
REQ-025 Reset pulsed during ACCESS -> psel/penable=0 same cycle, no rsp_valid, next command after release completes normally.
